// File: rtl/multdiv_pkg.sv
// Shared constants and FSM encoding for the multiply/divide sequencer.
package multdiv_pkg;

    localparam int unsigned ALUOP_W = 5;
    localparam int unsigned REG_W   = 5;

    localparam logic [ALUOP_W-1:0] ALUOP_MULT  = 5'd6;
    localparam logic [ALUOP_W-1:0] ALUOP_DIV   = 5'd7;
    localparam logic [REG_W-1:0]   RSTATUS_REG = 5'd30;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } mdState_t;

endpackage

// File: rtl/multdiv_cycle_counter.sv
// WAIT-cycle counter for the sequencer; flags the last allowed cycle before timeout.
module multdiv_cycle_counter #(
    parameter int unsigned TIMEOUT = 40,
    parameter int unsigned CNT_W   = 6
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal_c
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign terminal_c = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_sequencer.sv
// Issues mult/div ops from DX to the shared unit, stalls the pipe until the result
// (or a timeout) arrives, then presents a one-cycle writeback to XM.
module multdiv_sequencer
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 40,
    parameter int unsigned CNT_W   = 6
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               dx_valid,
    input  logic [ALUOP_W-1:0] aluOp,
    input  logic [REG_W-1:0]   dx_rd,
    input  logic [WIDTH-1:0]   dx_a,
    input  logic [WIDTH-1:0]   dx_b,
    input  logic               flush,
    input  logic               md_ready,
    input  logic [WIDTH-1:0]   md_result,
    input  logic               md_exc,
    output logic               ctrl_MULT,
    output logic               ctrl_DIV,
    output logic [WIDTH-1:0]   md_a,
    output logic [WIDTH-1:0]   md_b,
    output logic               md_stall,
    output logic               busy,
    output logic [REG_W-1:0]   busy_rd,
    output logic               wb_valid,
    output logic [REG_W-1:0]   wb_rd,
    output logic [WIDTH-1:0]   wb_data,
    output logic               wb_exc
);

    mdState_t         state;
    mdState_t         nextState;
    logic             isDivOp;
    logic             start;
    logic             loadOp;
    logic             capture;
    logic             timeoutHit;
    logic [REG_W-1:0] rdReg;

    assign isDivOp = (aluOp == ALUOP_DIV);
    // Gated by reset so the combinational stall also reads 0 while reset is held.
    assign start   = reset & dx_valid & ((aluOp == ALUOP_MULT) | isDivOp) & ~flush;

    multdiv_cycle_counter #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_counter (
        .clock      (clock),
        .reset      (reset),
        .clear      (state == ST_ISSUE),
        .enable     (state == ST_WAIT),
        .terminal_c (timeoutHit)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Flush wins over a same-cycle answer; an answer wins over the timeout.
    always_comb begin
        nextState = state;
        loadOp    = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    nextState = ST_ISSUE;
                    loadOp    = 1'b1;
                end
            end
            ST_ISSUE: nextState = flush ? ST_IDLE : ST_WAIT;
            ST_WAIT: begin
                if (flush) begin
                    nextState = ST_IDLE;
                end else if (md_ready || timeoutHit) begin
                    nextState = ST_DONE;
                    capture   = 1'b1;
                end
            end
            ST_DONE: nextState = ST_IDLE;
            default: nextState = ST_IDLE;
        endcase
    end

    assign md_stall = ((state == ST_IDLE) & start) | (state == ST_ISSUE) | (state == ST_WAIT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            md_a      <= '0;
            md_b      <= '0;
            rdReg     <= '0;
            ctrl_MULT <= 1'b0;
            ctrl_DIV  <= 1'b0;
            busy      <= 1'b0;
            busy_rd   <= '0;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            wb_exc    <= 1'b0;
        end else begin
            if (loadOp) begin
                md_a  <= dx_a;
                md_b  <= dx_b;
                rdReg <= dx_rd;
            end
            ctrl_MULT <= loadOp & ~isDivOp;
            ctrl_DIV  <= loadOp & isDivOp;
            busy      <= (nextState != ST_IDLE);
            busy_rd   <= (nextState == ST_IDLE) ? '0 : (loadOp ? dx_rd : rdReg);
            wb_valid  <= capture;
            wb_rd     <= capture ? rdReg : '0;
            wb_data   <= (capture & md_ready) ? md_result : '0;
            wb_exc    <= capture & (~md_ready | md_exc);
        end
    end

endmodule
